// File: rtl/cl2_csr_access_if.sv
// Bundle of the execute-stage request/response channel and the CSR array bus.
// The slave modport is the CSR access engine; the master modport is everything around it.
interface cl2_csr_access_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_op_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [XLEN-1:0]       req_wdata_i;
  logic                  req_src_zero_i;
  logic [1:0]            priv_i;

  logic [ADDR_WIDTH-1:0] csr_addr_o;
  logic [XLEN-1:0]       csr_rd_dat_i;
  logic                  csr_hit_i;
  logic                  csr_wr_en_o;
  logic [XLEN-1:0]       csr_wr_dat_o;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [XLEN-1:0]       rsp_rdata_o;
  logic                  rsp_illegal_o;

  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_src_zero_i, priv_i,
    output csr_rd_dat_i, csr_hit_i, rsp_ready_i,
    input  req_ready_o, csr_addr_o, csr_wr_en_o, csr_wr_dat_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_illegal_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_src_zero_i, priv_i,
    input  csr_rd_dat_i, csr_hit_i, rsp_ready_i,
    output req_ready_o, csr_addr_o, csr_wr_en_o, csr_wr_dat_o,
    output rsp_valid_o, rsp_rdata_o, rsp_illegal_o
  );
endinterface

// File: rtl/cl2_csr_access.sv
// CSR instruction engine: runs CSRRW/CSRRS/CSRRC as a read-modify-write on the CSR
// array and returns the old value or an illegal-instruction flag to the pipeline.
module cl2_csr_access #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cl2_csr_access_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] OP_RSV = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  state_t                state;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  src_zero_q;
  logic [1:0]            priv_q;
  logic [XLEN-1:0]       old_q;

  logic                  req_ready_q;
  logic                  wr_en_q;
  logic [XLEN-1:0]       wr_dat_q;
  logic                  rsp_valid_q;
  logic [XLEN-1:0]       rsp_rdata_q;
  logic                  rsp_illegal_q;

  logic                  do_write;
  logic                  illegal;
  logic [XLEN-1:0]       new_val;

  // Fault and new-value logic only reads latched request fields, never req_* directly.
  always_comb begin
    do_write = (op_q == OP_RW) | ~src_zero_q;
    illegal  = ~bus.csr_hit_i
             | (op_q == OP_RSV)
             | (priv_q < addr_q[9:8])
             | (do_write & (addr_q[11:10] == 2'b11));
    case (op_q)
      OP_RW:   new_val = wdata_q;
      OP_RS:   new_val = bus.csr_rd_dat_i | wdata_q;
      OP_RC:   new_val = bus.csr_rd_dat_i & ~wdata_q;
      default: new_val = bus.csr_rd_dat_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      op_q          <= OP_RSV;
      addr_q        <= '0;
      wdata_q       <= '0;
      src_zero_q    <= 1'b0;
      priv_q        <= 2'b00;
      old_q         <= '0;
      req_ready_q   <= 1'b1;
      wr_en_q       <= 1'b0;
      wr_dat_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i && req_ready_q) begin
            op_q        <= bus.req_op_i;
            addr_q      <= bus.req_addr_i;
            wdata_q     <= bus.req_wdata_i;
            src_zero_q  <= bus.req_src_zero_i;
            priv_q      <= bus.priv_i;
            req_ready_q <= 1'b0;
            state       <= READ;
          end
        end
        READ: begin
          old_q <= bus.csr_rd_dat_i;
          if (illegal) begin
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state         <= RESP;
          end else if (do_write) begin
            wr_en_q  <= 1'b1;
            wr_dat_q <= new_val;
            state    <= WRITE;
          end else begin
            rsp_rdata_q   <= bus.csr_rd_dat_i;
            rsp_illegal_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state         <= RESP;
          end
        end
        WRITE: begin
          wr_en_q       <= 1'b0;
          rsp_rdata_q   <= old_q;
          rsp_illegal_q <= 1'b0;
          rsp_valid_q   <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The address only changes on request accept, so it holds outside READ/WRITE.
  assign bus.csr_addr_o    = addr_q;
  assign bus.req_ready_o   = req_ready_q;
  assign bus.csr_wr_en_o   = wr_en_q;
  assign bus.csr_wr_dat_o  = wr_dat_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_cl2_csr_access.sv
// Directed bench for cl2_csr_access: a vector table of single requests against a
// one-register CSR model, plus backpressure and mid-operation reset sequences.
module tb_cl2_csr_access;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        src_zero;
    logic [1:0]  priv;
    logic [31:0] rd_dat;
    logic        hit;
    logic        exp_write;
    logic [31:0] exp_wdat;
    logic [31:0] exp_rdata;
    logic        exp_illegal;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cl2_csr_access_if #(.XLEN(32), .ADDR_WIDTH(12)) bus();

  cl2_csr_access #(.XLEN(32), .ADDR_WIDTH(12)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          strobe_count = 0;
  logic [31:0] last_wr_dat = '0;
  logic [11:0] last_wr_addr = '0;

  logic [11:0] cur_addr = '0;
  logic [31:0] cur_rd = '0;
  logic        cur_hit = 1'b0;

  // Single-register CSR model: wrong addresses read garbage and miss the decoder.
  always_comb begin
    bus.csr_rd_dat_i = (bus.csr_addr_o == cur_addr) ? cur_rd : 32'hDEAD_BEEF;
    bus.csr_hit_i    = (bus.csr_addr_o == cur_addr) & cur_hit;
  end

  always @(negedge clk) begin
    if (bus.csr_wr_en_o) begin
      strobe_count++;
      last_wr_dat  = bus.csr_wr_dat_o;
      last_wr_addr = bus.csr_addr_o;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int lat;
    int base;
    cur_addr = v.addr;
    cur_rd   = v.rd_dat;
    cur_hit  = v.hit;
    bus.req_op_i       = v.op;
    bus.req_addr_i     = v.addr;
    bus.req_wdata_i    = v.wdata;
    bus.req_src_zero_i = v.src_zero;
    bus.priv_i         = v.priv;
    bus.rsp_ready_i    = 1'b1;
    bus.req_valid_i    = 1'b1;
    base = strobe_count;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) bus.req_valid_i = 1'b0;
      if (bus.rsp_valid_o) begin
        lat = n;
        break;
      end
    end
    checkOutput($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    checkOutput($sformatf("v%0d_rdata", idx), bus.rsp_rdata_o, v.exp_rdata);
    checkOutput($sformatf("v%0d_illegal", idx), 32'(bus.rsp_illegal_o), 32'(v.exp_illegal));
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("v%0d_req_ready_after", idx), 32'(bus.req_ready_o), 32'd1);
    checkOutput($sformatf("v%0d_rsp_valid_after", idx), 32'(bus.rsp_valid_o), 32'd0);
    checkOutput($sformatf("v%0d_strobes", idx), 32'(strobe_count - base), 32'(v.exp_write));
    if (v.exp_write) begin
      checkOutput($sformatf("v%0d_wr_dat", idx), last_wr_dat, v.exp_wdat);
      checkOutput($sformatf("v%0d_wr_addr", idx), 32'(last_wr_addr), 32'(v.addr));
    end
  endtask

  vec_t vecs[15];

  initial begin
    int base;
    int lat;

    //         op     addr     wdata        sz    priv   rd_dat       hit   wr    wdat         rdata        ill   lat
    vecs[0]  = '{2'b01, 12'h340, 32'h1234_5678, 1'b0, 2'b11, 32'h0000_00AA, 1'b1, 1'b1, 32'h1234_5678, 32'h0000_00AA, 1'b0, 3};
    vecs[1]  = '{2'b10, 12'h340, 32'h0000_FFFF, 1'b0, 2'b11, 32'hF0F0_F0F0, 1'b1, 1'b1, 32'hF0F0_FFFF, 32'hF0F0_F0F0, 1'b0, 3};
    vecs[2]  = '{2'b11, 12'h340, 32'h0000_FFFF, 1'b0, 2'b11, 32'hF0F0_F0F0, 1'b1, 1'b1, 32'hF0F0_0000, 32'hF0F0_F0F0, 1'b0, 3};
    vecs[3]  = '{2'b10, 12'hF14, 32'hFFFF_FFFF, 1'b1, 2'b11, 32'h0000_0005, 1'b1, 1'b0, 32'h0,         32'h0000_0005, 1'b0, 2};
    vecs[4]  = '{2'b01, 12'hF14, 32'hFFFF_FFFF, 1'b1, 2'b11, 32'h0000_0005, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 2};
    vecs[5]  = '{2'b01, 12'h300, 32'h0000_0001, 1'b0, 2'b00, 32'h0000_1800, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 2};
    vecs[6]  = '{2'b01, 12'h340, 32'h0000_0001, 1'b0, 2'b11, 32'h0000_0077, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 2};
    vecs[7]  = '{2'b00, 12'h340, 32'h0000_0001, 1'b0, 2'b11, 32'h0000_0077, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 2};
    vecs[8]  = '{2'b10, 12'h140, 32'h0000_0022, 1'b0, 2'b01, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0122, 32'h0000_0100, 1'b0, 3};
    vecs[9]  = '{2'b11, 12'h140, 32'h0000_00FF, 1'b1, 2'b01, 32'h0000_0100, 1'b1, 1'b0, 32'h0,         32'h0000_0100, 1'b0, 2};
    vecs[10] = '{2'b10, 12'hC00, 32'h0000_00FF, 1'b1, 2'b00, 32'h0001_2345, 1'b1, 1'b0, 32'h0,         32'h0001_2345, 1'b0, 2};
    vecs[11] = '{2'b10, 12'hC00, 32'h0000_00FF, 1'b0, 2'b00, 32'h0001_2345, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 2};
    vecs[12] = '{2'b11, 12'h344, 32'hFFFF_FFFF, 1'b0, 2'b11, 32'h0000_ABCD, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_ABCD, 1'b0, 3};
    vecs[13] = '{2'b01, 12'h340, 32'h0000_0000, 1'b1, 2'b11, 32'h8000_0001, 1'b1, 1'b1, 32'h0000_0000, 32'h8000_0001, 1'b0, 3};
    vecs[14] = '{2'b10, 12'h340, 32'h0000_0001, 1'b1, 2'b01, 32'h8000_0001, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 2};

    bus.req_valid_i    = 1'b0;
    bus.req_op_i       = 2'b00;
    bus.req_addr_i     = '0;
    bus.req_wdata_i    = '0;
    bus.req_src_zero_i = 1'b0;
    bus.priv_i         = 2'b11;
    bus.rsp_ready_i    = 1'b1;

    // Reset held for two cycles, then check the idle state.
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_req_ready", 32'(bus.req_ready_o), 32'd1);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    checkOutput("reset_wr_en", 32'(bus.csr_wr_en_o), 32'd0);
    checkOutput("reset_csr_addr", 32'(bus.csr_addr_o), 32'd0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata_o, 32'd0);
    checkOutput("reset_rsp_illegal", 32'(bus.rsp_illegal_o), 32'd0);
    checkOutput("reset_strobes", 32'(strobe_count), 32'd0);

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

    // Backpressure: response must hold while a second request is refused.
    cur_addr = 12'h340;
    cur_rd   = 32'h0000_0055;
    cur_hit  = 1'b1;
    bus.req_op_i       = 2'b01;
    bus.req_addr_i     = 12'h340;
    bus.req_wdata_i    = 32'hA5A5_0000;
    bus.req_src_zero_i = 1'b0;
    bus.priv_i         = 2'b11;
    bus.rsp_ready_i    = 1'b0;
    bus.req_valid_i    = 1'b1;
    base = strobe_count;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.req_addr_i = 12'h341;
        bus.req_op_i   = 2'b00;
      end
      if (bus.rsp_valid_o) begin
        lat = n;
        break;
      end
    end
    checkOutput("bp_latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_rsp_valid_%0d", c), 32'(bus.rsp_valid_o), 32'd1);
      checkOutput($sformatf("bp_rdata_%0d", c), bus.rsp_rdata_o, 32'h0000_0055);
      checkOutput($sformatf("bp_illegal_%0d", c), 32'(bus.rsp_illegal_o), 32'd0);
      checkOutput($sformatf("bp_req_ready_%0d", c), 32'(bus.req_ready_o), 32'd0);
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_req_ready_after", 32'(bus.req_ready_o), 32'd1);
    checkOutput("bp_rsp_valid_after", 32'(bus.rsp_valid_o), 32'd0);
    checkOutput("bp_strobes", 32'(strobe_count - base), 32'd1);
    checkOutput("bp_wr_dat", last_wr_dat, 32'hA5A5_0000);
    checkOutput("bp_csr_addr_held", 32'(bus.csr_addr_o), 32'h340);

    // Reset while in READ: the pending write and response are dropped.
    bus.req_op_i       = 2'b01;
    bus.req_addr_i     = 12'h340;
    bus.req_wdata_i    = 32'h0BAD_F00D;
    bus.req_src_zero_i = 1'b0;
    bus.req_valid_i    = 1'b1;
    base = strobe_count;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    checkOutput("rst_mid_in_read", 32'(bus.req_ready_o), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_req_ready", 32'(bus.req_ready_o), 32'd1);
    checkOutput("rst_mid_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    checkOutput("rst_mid_csr_addr", 32'(bus.csr_addr_o), 32'd0);
    for (int c = 0; c < 4; c++) @(negedge clk);
    checkOutput("rst_mid_strobes", 32'(strobe_count - base), 32'd0);
    checkOutput("rst_mid_rsp_valid_later", 32'(bus.rsp_valid_o), 32'd0);
    checkOutput("rst_mid_req_ready_later", 32'(bus.req_ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cl2_csr_access.md
Name: cl2_csr_access

Overview:
- Initiator side of the per-field CSR write/read interface: executes CSR instruction requests (CSRRW/CSRRS/CSRRC) from the execute stage.
- Each request runs as a read-modify-write sequence on the CSR array and returns the old value, or an illegal-instruction flag, to the pipeline over a valid/ready response channel.
- Sits between the execute stage and the CSR array built from cl2_csr_field instances plus the address decoder.

Parameters:
- XLEN, 32, width of CSR data, operand and result.
- ADDR_WIDTH, 12, CSR address width; privilege and read-only bits are taken from [11:8].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready; high only in IDLE
- req_op_i  in  2  operation: 01 = RW, 10 = RS (set bits), 11 = RC (clear bits), 00 = reserved (illegal)
- req_addr_i  in  ADDR_WIDTH  CSR address
- req_wdata_i  in  XLEN  source operand (rs1 value or zimm)
- req_src_zero_i  in  1  source register/immediate index is zero; suppresses the write for RS/RC
- priv_i  in  2  current privilege level (00 = U, 01 = S, 11 = M)
- csr_addr_o  out  ADDR_WIDTH  address to the CSR decoder
- csr_rd_dat_i  in  XLEN  combinational read data for csr_addr_o
- csr_hit_i  in  1  csr_addr_o decodes to an implemented CSR
- csr_wr_en_o  out  1  single-cycle write strobe to the addressed field(s)
- csr_wr_dat_o  out  XLEN  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  XLEN  old CSR value; 0 when illegal
- rsp_illegal_o  out  1  request faulted; no write performed

Behaviour:
- Reset values (rst_i high at a clock edge): state = IDLE, req_ready_o = 1, rsp_valid_o = 0, csr_wr_en_o = 0, csr_addr_o = 0, csr_wr_dat_o = 0, rsp_rdata_o = 0, rsp_illegal_o = 0.
- Reset mid-operation aborts the sequence: no write strobe is issued after reset, and any pending response is dropped.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i && req_ready_o, latch op, addr, wdata, src_zero and priv, then go to READ.
- READ (1 cycle):
  - csr_addr_o = latched addr.
  - Sample csr_rd_dat_i into old_q and evaluate illegal.
  - illegal = !csr_hit_i | (op == 00) | (priv < addr[9:8]) | (do_write & (addr[11:10] == 2'b11)).
  - do_write = (op == RW) | !src_zero.
  - If illegal: rdata = 0, illegal = 1, go to RESP.
  - Else if do_write: go to WRITE.
  - Else: go to RESP with rdata = old_q.
- New value: RW → wdata; RS → old_q | wdata; RC → old_q & ~wdata. Full XLEN bitwise, no width extension.
- WRITE (1 cycle):
  - csr_wr_en_o = 1, csr_wr_dat_o = new value, csr_addr_o held.
  - Go to RESP with rdata = old_q.
- RESP:
  - rsp_valid_o = 1; rsp_rdata_o and rsp_illegal_o stable until accepted.
  - On rsp_ready_i, go to IDLE.
- csr_wr_en_o is high in exactly one cycle per legal writing request and never otherwise.
- csr_addr_o holds its last value outside READ/WRITE.
- Latency with rsp_ready_i held high:
  - Write path: accept edge → rsp_valid_o high 3 cycles later.
  - No-write or illegal path: 2 cycles later.
- Backpressure: rsp_ready_i low holds RESP indefinitely and no new request is accepted. req_ready_o is 0 in READ, WRITE and RESP.
- No combinational path from req_* to csr_* or from rsp_ready_i to req_ready_o. req_ready_o rises the cycle after the response handshake.

Test Plan:
- Reset then idle: hold rst_i 2 cycles → req_ready_o = 1, rsp_valid_o = 0, csr_wr_en_o never asserted.
- CSRRW, priv = M, addr 0x340, old = 0x0000_00AA, wdata = 0x1234_5678 → one csr_wr_en_o pulse with dat 0x1234_5678 in WRITE; rsp_rdata_o = 0x0000_00AA, illegal = 0, rsp_valid_o 3 cycles after accept.
- CSRRS and CSRRC on old 0xF0F0_F0F0 with wdata 0x0000_FFFF → RS writes 0xF0F0_FFFF, RC writes 0xF0F0_0000; both return 0xF0F0_F0F0.
- CSRRS with req_src_zero_i = 1 on read-only addr 0xF14 → no write strobe, illegal = 0, rdata = csr_rd_dat_i; same request as CSRRW → illegal = 1, rdata = 0, no strobe.
- Privilege and decode faults:
  - priv = U accessing 0x300 → illegal = 1, no write.
  - csr_hit_i = 0 → illegal = 1.
  - op = 00 → illegal = 1.
- Backpressure and reset:
  - rsp_ready_i low 5 cycles → rsp_valid_o and data stable, req_ready_o = 0 throughout.
  - rst_i asserted in READ → next cycle in IDLE, csr_wr_en_o stays 0, rsp_valid_o = 0.
